// File: rtl/memory_package.sv
// Shared Sv32 address/PTE types and TLB state encoding.
package memory_package;

    typedef struct packed {
        logic [19:0] vpn;
        logic [11:0] offset;
    } va_t;

    typedef struct packed {
        logic [21:0] ppn;
        logic [11:0] offset;
    } pa_t;

    typedef struct packed {
        logic [21:0] ppn;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } pte_t;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PTW_REQ  = 2'd1,
        ST_PTW_WAIT = 2'd2
    } tlb_state_e;

endpackage

// File: rtl/tlb_perm_check.sv
// Combinational Sv32 leaf/permission check for a single PTE and access.
module tlb_perm_check
    import memory_package::*;
(
    input  pte_t       pte_i,
    input  logic       is_read_i,
    input  logic       is_write_i,
    input  logic       is_execute_i,
    input  logic [1:0] priv_i,
    output logic       page_fault_o,
    output logic       is_leaf_o
);

    // PPN, RSW and G play no part in the permission decision.
    logic unused_bits;
    assign unused_bits = ^{pte_i.ppn, pte_i.rsw, pte_i.g};

    logic non_leaf;
    logic reserved_wr;

    assign non_leaf    = !(pte_i.r || pte_i.x);
    assign reserved_wr = pte_i.w && !pte_i.r;
    assign is_leaf_o   = pte_i.v && !non_leaf && !reserved_wr;

    // Any single violated rule is enough to fault the access.
    always_comb begin
        page_fault_o = 1'b0;
        if (!pte_i.v)                           page_fault_o = 1'b1;
        if (non_leaf)                           page_fault_o = 1'b1;
        if (reserved_wr)                        page_fault_o = 1'b1;
        if (is_read_i && !pte_i.r)              page_fault_o = 1'b1;
        if (is_write_i && !pte_i.w)             page_fault_o = 1'b1;
        if (is_execute_i && !pte_i.x)           page_fault_o = 1'b1;
        if (priv_i == PRIV_U && !pte_i.u)       page_fault_o = 1'b1;
        if (priv_i == PRIV_S && pte_i.u)        page_fault_o = 1'b1;
        if (!pte_i.a)                           page_fault_o = 1'b1;
        if (is_write_i && !pte_i.d)             page_fault_o = 1'b1;
    end

endmodule

// File: rtl/sv32_tlb.sv
// Fully-associative Sv32 TLB with round-robin refill from the page table.
module sv32_tlb
    import memory_package::*;
#(
    parameter int TLB_ENTRIES = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  va_t         req_va,
    input  logic        req_is_read,
    input  logic        req_is_write,
    input  logic        req_is_execute,
    input  logic [1:0]  req_priv,
    output logic        resp_valid,
    output pa_t         resp_pa,
    output logic        resp_page_fault,
    output logic        resp_access_fault,
    output logic        ptw_req_valid,
    input  logic        ptw_req_ready,
    output logic [19:0] ptw_req_vpn,
    input  logic        ptw_resp_valid,
    input  pte_t        ptw_resp_pte,
    input  logic        ptw_resp_access_fault
);

    localparam int IDX_W = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;

    tlb_state_e             state_q;
    logic [TLB_ENTRIES-1:0] valid_q;
    logic [19:0]            vpn_q [TLB_ENTRIES];
    pte_t                   pte_q [TLB_ENTRIES];
    logic [IDX_W-1:0]       rr_q;
    logic                   flush_pend_q;

    // Request captured on a miss; the permission check replays it on the walk result.
    va_t        lat_va_q;
    logic       lat_rd_q, lat_wr_q, lat_ex_q;
    logic [1:0] lat_priv_q;

    logic resp_valid_q, resp_pf_q, resp_af_q;
    pa_t  resp_pa_q;
    logic ptw_req_valid_q;
    logic [19:0] ptw_req_vpn_q;

    assign req_ready         = (state_q == ST_IDLE) && !flush && !RST;
    assign resp_valid        = resp_valid_q;
    assign resp_pa           = resp_pa_q;
    assign resp_page_fault   = resp_pf_q;
    assign resp_access_fault = resp_af_q;
    assign ptw_req_valid     = ptw_req_valid_q;
    assign ptw_req_vpn       = ptw_req_vpn_q;

    // Parallel tag compare across all entries.
    logic [TLB_ENTRIES-1:0] hit_vec;
    generate
        for (genvar gi = 0; gi < TLB_ENTRIES; gi++) begin : g_tag
            assign hit_vec[gi] = valid_q[gi] && (vpn_q[gi] == req_va.vpn);
        end
    endgenerate

    logic hit;
    pte_t hit_pte;
    assign hit = |hit_vec;

    // Entries are unique by VPN, so OR-ing the matching payloads selects the hit.
    always_comb begin
        hit_pte = '0;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            if (hit_vec[i]) hit_pte = hit_pte | pte_q[i];
        end
    end

    // One checker shared by the hit path (IDLE) and the walk-return path (PTW_WAIT).
    logic       in_wait;
    pte_t       chk_pte;
    logic       chk_rd, chk_wr, chk_ex;
    logic [1:0] chk_priv;
    logic [11:0] chk_off;
    logic       perm_fault, perm_leaf;
    pa_t        ok_pa;

    assign in_wait  = (state_q == ST_PTW_WAIT);
    assign chk_pte  = in_wait ? ptw_resp_pte : hit_pte;
    assign chk_rd   = in_wait ? lat_rd_q   : req_is_read;
    assign chk_wr   = in_wait ? lat_wr_q   : req_is_write;
    assign chk_ex   = in_wait ? lat_ex_q   : req_is_execute;
    assign chk_priv = in_wait ? lat_priv_q : req_priv;
    assign chk_off  = in_wait ? lat_va_q.offset : req_va.offset;
    assign ok_pa    = {chk_pte.ppn, chk_off};

    tlb_perm_check u_perm (
        .pte_i        (chk_pte),
        .is_read_i    (chk_rd),
        .is_write_i   (chk_wr),
        .is_execute_i (chk_ex),
        .priv_i       (chk_priv),
        .page_fault_o (perm_fault),
        .is_leaf_o    (perm_leaf)
    );

    logic [IDX_W-1:0] rr_next;
    assign rr_next = (rr_q == IDX_W'(TLB_ENTRIES - 1)) ? '0 : rr_q + IDX_W'(1);

    // Control FSM, entry storage and registered response outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q         <= ST_IDLE;
            valid_q         <= '0;
            rr_q            <= '0;
            flush_pend_q    <= 1'b0;
            lat_va_q        <= '0;
            lat_rd_q        <= 1'b0;
            lat_wr_q        <= 1'b0;
            lat_ex_q        <= 1'b0;
            lat_priv_q      <= 2'b00;
            resp_valid_q    <= 1'b0;
            resp_pa_q       <= '0;
            resp_pf_q       <= 1'b0;
            resp_af_q       <= 1'b0;
            ptw_req_valid_q <= 1'b0;
            ptw_req_vpn_q   <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_pa_q    <= '0;
            resp_pf_q    <= 1'b0;
            resp_af_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (flush) begin
                        valid_q      <= '0;
                        rr_q         <= '0;
                        flush_pend_q <= 1'b0;
                    end else if (req_valid) begin
                        if (req_priv == PRIV_M) begin
                            resp_valid_q <= 1'b1;
                            resp_pa_q    <= {2'b00, req_va};
                        end else if (hit) begin
                            resp_valid_q <= 1'b1;
                            resp_pf_q    <= perm_fault;
                            resp_pa_q    <= perm_fault ? '0 : ok_pa;
                        end else begin
                            lat_va_q        <= req_va;
                            lat_rd_q        <= req_is_read;
                            lat_wr_q        <= req_is_write;
                            lat_ex_q        <= req_is_execute;
                            lat_priv_q      <= req_priv;
                            ptw_req_valid_q <= 1'b1;
                            ptw_req_vpn_q   <= req_va.vpn;
                            state_q         <= ST_PTW_REQ;
                        end
                    end
                end
                ST_PTW_REQ: begin
                    if (flush) flush_pend_q <= 1'b1;
                    if (ptw_req_ready) begin
                        ptw_req_valid_q <= 1'b0;
                        state_q         <= ST_PTW_WAIT;
                    end
                end
                ST_PTW_WAIT: begin
                    if (flush) flush_pend_q <= 1'b1;
                    if (ptw_resp_valid) begin
                        resp_valid_q <= 1'b1;
                        state_q      <= ST_IDLE;
                        if (ptw_resp_access_fault) begin
                            resp_af_q <= 1'b1;
                        end else begin
                            resp_pf_q <= perm_fault;
                            resp_pa_q <= perm_fault ? '0 : ok_pa;
                        end
                        // A flush seen during the walk wins over the fill.
                        if (flush_pend_q || flush) begin
                            valid_q      <= '0;
                            rr_q         <= '0;
                            flush_pend_q <= 1'b0;
                        end else if (!ptw_resp_access_fault && perm_leaf) begin
                            valid_q[rr_q] <= 1'b1;
                            vpn_q[rr_q]   <= lat_va_q.vpn;
                            pte_q[rr_q]   <= ptw_resp_pte;
                            rr_q          <= rr_next;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sv32_tlb.sv
// Self-checking bench for sv32_tlb: directed vector table, corner sequences, random vs model.
module tb_sv32_tlb;
    import memory_package::*;

    localparam int N = 8;

    logic CLK = 1'b0;
    logic RST, flush, req_valid, req_ready;
    va_t  req_va;
    logic req_is_read, req_is_write, req_is_execute;
    logic [1:0] req_priv;
    logic resp_valid;
    pa_t  resp_pa;
    logic resp_page_fault, resp_access_fault;
    logic ptw_req_valid, ptw_req_ready;
    logic [19:0] ptw_req_vpn;
    logic ptw_resp_valid;
    pte_t ptw_resp_pte;
    logic ptw_resp_access_fault;

    sv32_tlb #(.TLB_ENTRIES(N)) dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_va(req_va),
        .req_is_read(req_is_read), .req_is_write(req_is_write),
        .req_is_execute(req_is_execute), .req_priv(req_priv),
        .resp_valid(resp_valid), .resp_pa(resp_pa),
        .resp_page_fault(resp_page_fault), .resp_access_fault(resp_access_fault),
        .ptw_req_valid(ptw_req_valid), .ptw_req_ready(ptw_req_ready),
        .ptw_req_vpn(ptw_req_vpn), .ptw_resp_valid(ptw_resp_valid),
        .ptw_resp_pte(ptw_resp_pte), .ptw_resp_access_fault(ptw_resp_access_fault)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Page-table contents served by the bench; unmapped VPNs get a full-permission S page.
    logic [31:0] pt_mem [int];
    bit          pt_af  [int];

    function automatic pte_t pt_get(input logic [19:0] vpn);
        if (pt_mem.exists(int'(vpn))) return pte_t'(pt_mem[int'(vpn)]);
        return pte_t'({2'b01, vpn, 2'b00, 8'hCF});
    endfunction

    function automatic bit pt_get_af(input logic [19:0] vpn);
        if (pt_af.exists(int'(vpn))) return pt_af[int'(vpn)];
        return 1'b0;
    endfunction

    // Reference: permission rules and a FIFO of cached translations.
    function automatic bit ref_fault(input pte_t p, input int acc, input logic [1:0] priv);
        bit f = 0;
        if (!p.v) f = 1;
        if (!p.r && !p.x) f = 1;
        if (p.w && !p.r) f = 1;
        if (acc == 0 && !p.r) f = 1;
        if (acc == 1 && !p.w) f = 1;
        if (acc == 2 && !p.x) f = 1;
        if (priv == PRIV_U && !p.u) f = 1;
        if (priv == PRIV_S && p.u) f = 1;
        if (!p.a) f = 1;
        if (acc == 1 && !p.d) f = 1;
        return f;
    endfunction

    typedef struct { logic [19:0] vpn; pte_t pte; } ment_t;
    ment_t mtlb[$];

    function automatic int m_find(input logic [19:0] vpn);
        foreach (mtlb[i]) if (mtlb[i].vpn == vpn) return i;
        return -1;
    endfunction

    task automatic model_xact(input logic [31:0] va, input int acc, input logic [1:0] priv,
                              output logic [33:0] pa, output bit pf, output bit af, output bit walk);
        pte_t p;
        int   idx;
        pa = '0; pf = 0; af = 0; walk = 0;
        if (priv == PRIV_M) begin
            pa = {2'b00, va};
        end else begin
            idx = m_find(va[31:12]);
            if (idx >= 0) p = mtlb[idx].pte;
            else begin
                walk = 1;
                p = pt_get(va[31:12]);
                af = pt_get_af(va[31:12]);
            end
            if (!af) begin
                pf = ref_fault(p, acc, priv);
                if (!pf) pa = {p.ppn, va[11:0]};
            end
            if (walk && !af && p.v && (p.r || p.x) && !(p.w && !p.r)) begin
                mtlb.push_back('{vpn: va[31:12], pte: p});
                if (mtlb.size() > N) void'(mtlb.pop_front());
            end
        end
    endtask

    // Drives one request and services any page-table walk it causes.
    task automatic xact(input logic [31:0] va, input int acc, input logic [1:0] priv,
                        input int resp_delay, input bit flush_mid,
                        output logic [33:0] pa, output bit pf, output bit af,
                        output bit walked, output int lat);
        int cyc, cnt;
        bit got;
        pa = '0; pf = 0; af = 0; walked = 0; lat = 0; got = 0; cnt = 0; cyc = 0;
        @(negedge CLK);
        req_va = va;
        req_is_read = (acc == 0); req_is_write = (acc == 1); req_is_execute = (acc == 2);
        req_priv = priv;
        req_valid = 1'b1;
        while (!req_ready && cyc < 20) begin
            @(negedge CLK);
            cyc++;
        end
        if (!req_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: req_ready stayed low for va 0x%08h", va);
        end
        @(posedge CLK);
        #1 req_valid = 1'b0;
        while (!got && lat < 100) begin
            @(negedge CLK);
            lat++;
            ptw_req_ready = 1'b0; ptw_resp_valid = 1'b0; ptw_resp_access_fault = 1'b0; flush = 1'b0;
            if (resp_valid) begin
                pa = resp_pa; pf = resp_page_fault; af = resp_access_fault; got = 1;
            end else if (ptw_req_valid) begin
                if (!walked) chk("ptw_req_vpn", ptw_req_vpn, va[31:12]);
                walked = 1;
                ptw_req_ready = 1'b1;
                cnt = resp_delay;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    ptw_resp_valid = 1'b1;
                    ptw_resp_pte = pt_get(va[31:12]);
                    ptw_resp_access_fault = pt_get_af(va[31:12]);
                end else if (flush_mid) begin
                    flush = 1'b1;
                end
            end
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL resp_timeout: no resp_valid for va 0x%08h", va);
        end
    endtask

    // Run one request and compare against explicit expectations.
    task automatic apply(input string name, input logic [31:0] va, input int acc, input logic [1:0] priv,
                         input logic [33:0] e_pa, input bit e_pf, input bit e_af, input bit e_walk,
                         input int delay = 1, input bit flush_mid = 0);
        logic [33:0] pa; bit pf, af, walked; int lat;
        xact(va, acc, priv, delay, flush_mid, pa, pf, af, walked, lat);
        chk({name, ".pa"}, pa, e_pa);
        chk({name, ".pf"}, pf, e_pf);
        chk({name, ".af"}, af, e_af);
        chk({name, ".walk"}, walked, e_walk);
        if (!e_walk) chk({name, ".lat"}, lat, 1);
        $display("xact %s va=%08h acc=%0d priv=%0d pa=%09h pf=%0b af=%0b walk=%0b lat=%0d",
                 name, va, acc, priv, pa, pf, af, walked, lat);
    endtask

    task automatic do_flush();
        @(negedge CLK);
        flush = 1'b1;
        #1 chk("ready_low_during_flush", req_ready, 1'b0);
        @(negedge CLK);
        flush = 1'b0;
        mtlb.delete();
    endtask

    typedef struct {
        string       name;
        logic [31:0] va;
        int          acc;
        logic [1:0]  priv;
        logic [33:0] pa;
        bit          pf;
        bit          af;
        bit          walk;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [19:0] v;
        logic [31:0] rva;
        logic [1:0]  rpriv;
        logic [33:0] e_pa;
        bit          e_pf, e_af, e_walk;
        int          racc;

        RST = 1'b1; flush = 1'b0; req_valid = 1'b0; req_va = '0;
        req_is_read = 1'b0; req_is_write = 1'b0; req_is_execute = 1'b0; req_priv = PRIV_S;
        ptw_req_ready = 1'b0; ptw_resp_valid = 1'b0; ptw_resp_pte = '0; ptw_resp_access_fault = 1'b0;

        pt_mem[5]  = 32'h000108C7;   // PPN 0x42, D A W R V
        pt_mem[6]  = 32'h000198C3;   // PPN 0x66, D A R V (read-only)
        pt_mem[7]  = 32'h0001DC49;   // PPN 0x77, A X V (supervisor exec)
        pt_af[8]   = 1'b1;
        pt_mem[9]  = 32'h00026401;   // pointer (non-leaf)
        pt_mem[10] = 32'h0002A853;   // PPN 0xAA, A U R V (user read)
        pt_mem[11] = 32'h0002EC03;   // PPN 0xBB, R V, A=0
        pt_mem[12] = 32'h000330C5;   // PPN 0xCC, D A W V (W without R)

        vecs.push_back('{"s_read_miss",   32'h00005123, 0, PRIV_S, 34'h042123, 0, 0, 1});
        vecs.push_back('{"s_read_hit",    32'h00005123, 0, PRIV_S, 34'h042123, 0, 0, 0});
        vecs.push_back('{"s_write_hit",   32'h00005123, 1, PRIV_S, 34'h042123, 0, 0, 0});
        vecs.push_back('{"s_exec_nox",    32'h00005123, 2, PRIV_S, 34'h0,      1, 0, 0});
        vecs.push_back('{"ro_read_miss",  32'h00006ABC, 0, PRIV_S, 34'h066ABC, 0, 0, 1});
        vecs.push_back('{"ro_write_hit",  32'h00006ABC, 1, PRIV_S, 34'h0,      1, 0, 0});
        vecs.push_back('{"u_fetch_supg",  32'h00007ABC, 2, PRIV_U, 34'h0,      1, 0, 1});
        vecs.push_back('{"m_fetch",       32'h00007ABC, 2, PRIV_M, 34'h007ABC, 0, 0, 0});
        vecs.push_back('{"s_fetch_hit",   32'h00007ABC, 2, PRIV_S, 34'h077ABC, 0, 0, 0});
        vecs.push_back('{"acc_fault",     32'h00008000, 0, PRIV_S, 34'h0,      0, 1, 1});
        vecs.push_back('{"acc_fault_again", 32'h00008000, 0, PRIV_S, 34'h0,    0, 1, 1});
        vecs.push_back('{"non_leaf",      32'h00009010, 0, PRIV_S, 34'h0,      1, 0, 1});
        vecs.push_back('{"non_leaf_again", 32'h00009010, 0, PRIV_S, 34'h0,     1, 0, 1});
        vecs.push_back('{"s_on_upage",    32'h0000A004, 0, PRIV_S, 34'h0,      1, 0, 1});
        vecs.push_back('{"u_on_upage",    32'h0000A004, 0, PRIV_U, 34'h0AA004, 0, 0, 0});
        vecs.push_back('{"u_write_nod",   32'h0000A004, 1, PRIV_U, 34'h0,      1, 0, 0});
        vecs.push_back('{"a_clear_miss",  32'h0000B000, 0, PRIV_S, 34'h0,      1, 0, 1});
        vecs.push_back('{"a_clear_hit",   32'h0000B000, 0, PRIV_S, 34'h0,      1, 0, 0});
        vecs.push_back('{"w_no_r",        32'h0000C000, 1, PRIV_S, 34'h0,      1, 0, 1});
        vecs.push_back('{"w_no_r_again",  32'h0000C000, 1, PRIV_S, 34'h0,      1, 0, 1});

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst.req_ready", req_ready, 1'b0);
        chk("rst.resp_valid", resp_valid, 1'b0);
        chk("rst.resp_pa", resp_pa, 34'h0);
        chk("rst.faults", {resp_page_fault, resp_access_fault}, 2'b00);
        chk("rst.ptw_req_valid", ptw_req_valid, 1'b0);
        chk("rst.ptw_req_vpn", ptw_req_vpn, 20'h0);
        RST = 1'b0;
        @(negedge CLK);
        chk("post_rst.req_ready", req_ready, 1'b1);

        // Directed vector table
        foreach (vecs[i])
            apply(vecs[i].name, vecs[i].va, vecs[i].acc, vecs[i].priv,
                  vecs[i].pa, vecs[i].pf, vecs[i].af, vecs[i].walk);

        // Flush in IDLE drops every cached translation
        do_flush();
        apply("after_flush", 32'h00005123, 0, PRIV_S, 34'h042123, 0, 0, 1);

        // Round-robin eviction: N+1 fills overwrite slot 0 and leave the pointer at 1
        do_flush();
        for (int i = 0; i <= N; i++) begin
            v = 20'h100 + 20'(i);
            apply("fill", {v, 12'h000}, 0, PRIV_S, {2'b01, v, 12'h000}, 0, 0, 1);
        end
        apply("evict_last_hit", 32'h00108000, 0, PRIV_S, {2'b01, 20'h108, 12'h000}, 0, 0, 0);
        apply("evict_mid_hit",  32'h00102000, 0, PRIV_S, {2'b01, 20'h102, 12'h000}, 0, 0, 0);
        apply("evict_first",    32'h00100000, 0, PRIV_S, {2'b01, 20'h100, 12'h000}, 0, 0, 1);
        apply("evict_second",   32'h00101000, 0, PRIV_S, {2'b01, 20'h101, 12'h000}, 0, 0, 1);

        // Flush during PTW_WAIT: response delivered, nothing cached afterwards
        apply("flush_in_wait", 32'h00150444, 0, PRIV_S, {2'b01, 20'h150, 12'h444}, 0, 0, 1, 3, 1);
        apply("fw_walked_miss", 32'h00150000, 0, PRIV_S, {2'b01, 20'h150, 12'h000}, 0, 0, 1);
        apply("fw_prior_miss",  32'h00108000, 0, PRIV_S, {2'b01, 20'h108, 12'h000}, 0, 0, 1);

        // Randomized traffic against the reference model
        do_flush();
        for (int i = 0; i < 12; i++) begin
            logic [7:0] fl;
            fl = 8'($urandom);
            fl[0] = ($urandom_range(0, 7) != 0);
            fl[6] = ($urandom_range(0, 5) != 0);
            pt_mem[32'h200 + i] = {22'($urandom), 2'b00, fl};
            pt_af[32'h200 + i]  = ($urandom_range(0, 9) == 0);
        end
        for (int i = 0; i < 250; i++) begin
            logic [33:0] pa; bit pf, af, walked; int lat;
            if ($urandom_range(0, 24) == 0) do_flush();
            v = 20'h200 + 20'($urandom_range(0, 11));
            rva = {v, 12'($urandom)};
            racc = $urandom_range(0, 2);
            case ($urandom_range(0, 3))
                0:       rpriv = PRIV_U;
                3:       rpriv = PRIV_M;
                default: rpriv = PRIV_S;
            endcase
            model_xact(rva, racc, rpriv, e_pa, e_pf, e_af, e_walk);
            xact(rva, racc, rpriv, 1, 0, pa, pf, af, walked, lat);
            chk("rand.pa", pa, e_pa);
            chk("rand.pf", pf, e_pf);
            chk("rand.af", af, e_af);
            chk("rand.walk", walked, e_walk);
            if (!e_walk) chk("rand.lat", lat, 1);
            $display("xact rand%0d va=%08h acc=%0d priv=%0d pa=%09h pf=%0b af=%0b walk=%0b",
                     i, rva, racc, rpriv, pa, pf, af, walked);
        end

        // Reset mid-walk aborts it; a late walk response in IDLE is ignored
        @(negedge CLK);
        req_va = 32'h00300000; req_is_read = 1'b1; req_is_write = 1'b0; req_is_execute = 1'b0;
        req_priv = PRIV_S; req_valid = 1'b1;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        @(negedge CLK);
        chk("midwalk.ptw_req_valid", ptw_req_valid, 1'b1);
        chk("midwalk.ptw_req_vpn", ptw_req_vpn, 20'h300);
        RST = 1'b1;
        @(negedge CLK);
        chk("midwalk.rst_ready", req_ready, 1'b0);
        chk("midwalk.rst_ptw_valid", ptw_req_valid, 1'b0);
        RST = 1'b0;
        ptw_resp_valid = 1'b1;
        ptw_resp_pte = pt_get(20'h300);
        @(negedge CLK);
        chk("late_resp.resp_valid", resp_valid, 1'b0);
        chk("late_resp.ready", req_ready, 1'b1);
        ptw_resp_valid = 1'b0;
        apply("post_abort_miss", 32'h00300010, 0, PRIV_S, {2'b01, 20'h300, 12'h010}, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
